// File: rtl/score_ram_arbiter.sv
// Two-port round-robin arbiter in front of a 32x14 score RAM with a
// post-reset clear sweep; port 0 reads/writes, port 1 is read-only.
module score_ram_arbiter #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [4:0]  addr0,
  input  logic [13:0] wdata0,
  input  logic        req1,
  input  logic [4:0]  addr1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [13:0] rdata,
  output logic [4:0]  ram_addr,
  output logic [13:0] ram_wdata,
  output logic        ram_we,
  input  logic [13:0] ram_q,
  output logic        init_busy
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [1:0]  r_wait;
  logic        r_port;
  logic        r_wr;
  logic        r_last;
  logic        r_gnt0, r_gnt1, r_done0, r_done1;
  logic [13:0] r_rdata;
  logic [4:0]  r_ram_addr;
  logic [13:0] r_ram_wdata;
  logic        r_ram_we;
  logic        r_init_busy;
  logic        w_pick1;

  // r_last = 1 means port 1 was served last, so port 0 wins a tie
  assign w_pick1 = req1 && (!req0 || !r_last);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_port      <= 1'b0;
      r_wr        <= 1'b0;
      r_last      <= 1'b1;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_rdata     <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_init_busy <= 1'b1;
    end else begin
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_ram_we <= 1'b0;
      case (r_state)
        S_INIT: begin
          // counter has wrapped after presenting address 31
          if (r_ram_we && (r_cnt == '0)) begin
            r_init_busy <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_ram_we    <= 1'b1;
            r_ram_wdata <= '0;
            r_ram_addr  <= r_cnt;
            r_cnt       <= r_cnt + 5'd1;
          end
        end
        S_IDLE: begin
          if (req0 || req1) begin
            r_state <= S_ACCESS;
            r_port  <= w_pick1;
            r_last  <= w_pick1;
            if (w_pick1) begin
              r_gnt1     <= 1'b1;
              r_ram_addr <= addr1;
              r_wr       <= 1'b0;
            end else begin
              r_gnt0     <= 1'b1;
              r_ram_addr <= addr0;
              r_wr       <= we0;
              r_ram_we   <= we0;
              if (we0) r_ram_wdata <= wdata0;
            end
          end
        end
        S_ACCESS: begin
          if (r_wr) begin
            r_state <= S_DONE;
            r_done0 <= 1'b1;
          end else begin
            r_state <= S_WAIT;
            r_wait  <= '0;
          end
        end
        S_WAIT: begin
          if (r_wait == 2'(RD_LAT - 1)) begin
            r_rdata <= ram_q;
            r_state <= S_DONE;
            r_done0 <= !r_port;
            r_done1 <= r_port;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign rdata     = r_rdata;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_we    = r_ram_we;
  assign init_busy = r_init_busy;

endmodule
